sync_trial_sequencer: RTL and testbench
=======================================

// Module: sync_trial_sequencer
// PURPOSE
//  clk-domain controller that sequences metastability trials on a clk1-sampled launch bus.
//  Per trial: hold launch_q at OLD, flip to NEW, then wait for one capture from the clk1 side.
//  Each capture must equal OLD or NEW; any other value is an incoherent multi-bit capture (error).
//  The capture side reports through a toggle req/ack handshake, so no clk1 logic lives here.
// PARAMETERS
//  W          4    launch/capture bus width
//  SYNC_STG   2    synchronizer depth on cap_req_tog (min 2)
//  HOLD_CYC   4    clk cycles launch_q holds OLD before the flip (min 1)
//  TMO_CYC    255  clk cycles LAUNCH waits for a capture before declaring a timeout
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  start        in   1   1-cycle pulse: begin a run (ignored while busy)
//  abort        in   1   level/pulse: end the run now, go to IDLE
//  cfg_trials   in   16  number of trials in the run (sampled at start)
//  cfg_mode     in   2   NEW=f(OLD): 0 bin+1, 1 Gray+1, 2 ~OLD, 3 OLD^1 (sampled at start)
//  launch_q     out  W   launch bus to the clk1 sampler (registered)
//  cap_req_tog  in   1   toggles once per capture (clk1 domain, async here)
//  cap_data     in   W   captured value; stable from req toggle until matching ack toggle
//  cap_ack_tog  out  1   toggled once per accepted req event
//  busy         out  1   high in SETUP/LAUNCH/CHECK
//  done         out  1   high in DONE until next start
//  trial_cnt    out  16  trials completed this run
//  err_cnt      out  16  incoherent captures, saturates at 16'hFFFF
//  tmo_cnt      out  8   timed-out trials, saturates at 8'hFF
//  last_bad     out  W   most recent offending cap_data
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; sync chain and ack toggle 0.
//  Req event: synced req (after SYNC_STG flops) != its previous value -> 1-cycle ev.
//   Every ev toggles cap_ack_tog next cycle, in every state (handshake never stalls).
//   ev is evaluated only in LAUNCH; elsewhere it is acked and discarded.
//  FSM:
//   IDLE : start -> latch cfg, clear counters, done=0; cfg_trials==0 -> DONE, else SETUP.
//   SETUP: launch_q=OLD; wait HOLD_CYC cycles -> LAUNCH, launch_q<=NEW same edge.
//   LAUNCH: ev -> register cap_data -> CHECK; TMO_CYC cycles w/o ev -> tmo_cnt++,
//    trial_cnt++, then SETUP or DONE.
//   CHECK: data in {OLD,NEW} ok; else err_cnt++, last_bad<=data. trial_cnt++;
//    OLD<=NEW; trial_cnt==cfg_trials -> DONE else SETUP.
//   DONE : done=1, busy=0; start -> new run as from IDLE.
//  First OLD after start = 0. OLD carries across trials (pattern walks, wraps mod 2^W).
//  Gray+1: NEW = g(b(OLD)+1) with b = Gray->binary; exactly one bit differs.
//  abort: any state -> IDLE next edge; counters hold; done stays 0; launch_q holds.
//  abort wins over start on the same cycle; start while busy ignored.
//  ev coinciding with a timeout: ev wins (trial counted as capture, not timeout).
//  Latency: cap_req_tog edge -> ev after SYNC_STG+1 clk; ev -> ack 1 clk; ev -> counter 2 clk.
//  Saturating counters never wrap; trial_cnt bounded by cfg_trials.
// STRUCTURE
//  Package sync_exp_pkg: state enum (IDLE,SETUP,LAUNCH,CHECK,DONE), mode codes,
//   bin2gray/gray2bin functions, counter widths.
//  Sub-module toggle_sync: SYNC_STG flop chain + change detector -> ev.
//  Top: FSM, pattern gen, hold/timeout counter (shared), stat counters, ack toggle.
// TESTING
//  cfg_trials=8, mode 0, capture model echoes NEW -> done, trial_cnt=8, err=0, tmo=0.
//  mode 1, trials=16: every launch_q flip differs in 1 bit, launch_q returns to 0 after 16.
//  Inject cap_data=4'hA when OLD=3,NEW=4 -> err_cnt=1, last_bad=4'hA; OLD/NEW captures no error.
//  Silence capture side, trials=2 -> each trial ends after TMO_CYC, tmo_cnt=2, done=1.
//  abort during LAUNCH of trial 3 -> IDLE, done=0, trial_cnt=2; req toggles in IDLE all acked.
//  Assert rst_n low mid-run -> all outputs 0 immediately; cfg_trials=0 start -> done next cycle.

Source files
------------

// File: rtl/sync_exp_pkg.sv
// rtl/sync_exp_pkg.sv - shared types, mode codes and Gray helpers for the sync trial sequencer
// Contents: state_t FSM encoding, MODE_* pattern codes, counter widths,
//           bin2gray/gray2bin (32-bit, callers truncate to their bus width).
package sync_exp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LAUNCH,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_INV  = 2'd2;
    localparam logic [1:0] MODE_LSB  = 2'd3;

    localparam int TRIAL_W = 16;
    localparam int ERR_W   = 16;
    localparam int TMO_W   = 8;
    localparam int TIMER_W = 16;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down recovers the binary value.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/toggle_sync.sv
// rtl/toggle_sync.sv - synchronizer chain plus change detector for a toggle request
// Ports: clk, rst_n (async active-low), tog_in (asynchronous toggle),
//        ev (registered 1-cycle pulse per toggle, SYNC_STG+1 clocks after the edge).
module toggle_sync #(
    parameter int SYNC_STG = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tog_in,
    output logic ev
);

    logic [SYNC_STG-1:0] sync_q;
    logic                prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            ev     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], tog_in};
            prev_q <= sync_q[SYNC_STG-1];
            ev     <= sync_q[SYNC_STG-1] ^ prev_q;
        end
    end

endmodule

// File: rtl/sync_trial_sequencer.sv
// rtl/sync_trial_sequencer.sv - sequences OLD->NEW launch trials and scores clk1-side captures
// Ports: clk, rst_n; start/abort/cfg_trials/cfg_mode control; launch_q to the sampler;
//        cap_req_tog/cap_data/cap_ack_tog toggle handshake; busy/done status;
//        trial_cnt, err_cnt, tmo_cnt, last_bad statistics.
module sync_trial_sequencer
    import sync_exp_pkg::*;
#(
    parameter int W        = 4,
    parameter int SYNC_STG = 2,
    parameter int HOLD_CYC = 4,
    parameter int TMO_CYC  = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [TRIAL_W-1:0] cfg_trials,
    input  logic [1:0]         cfg_mode,
    output logic [W-1:0]       launch_q,
    input  logic               cap_req_tog,
    input  logic [W-1:0]       cap_data,
    output logic               cap_ack_tog,
    output logic               busy,
    output logic               done,
    output logic [TRIAL_W-1:0] trial_cnt,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [TMO_W-1:0]   tmo_cnt,
    output logic [W-1:0]       last_bad
);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] tmr_q, tmr_d;
    logic [W-1:0]       old_q, old_d, new_val, gray_inc;
    logic [W-1:0]       launch_d, cap_q, cap_d, last_bad_d;
    logic [TRIAL_W-1:0] trials_q, trials_d, trial_d, trial_nxt;
    logic [1:0]         mode_q, mode_d;
    logic [ERR_W-1:0]   err_d;
    logic [TMO_W-1:0]   tmo_d;
    logic               ev;

    toggle_sync #(.SYNC_STG(SYNC_STG)) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .tog_in(cap_req_tog),
        .ev    (ev)
    );

    // NEW is always derived from the current OLD; it only becomes OLD once a
    // capture has been checked.
    always_comb begin
        gray_inc = W'(gray2bin(32'(old_q)) + 32'd1);
        new_val  = '0;
        case (mode_q)
            MODE_BIN:  new_val = old_q + 1'b1;
            MODE_GRAY: new_val = W'(bin2gray(32'(gray_inc)));
            MODE_INV:  new_val = ~old_q;
            MODE_LSB:  new_val = old_q ^ W'(1);
            default:   new_val = old_q;
        endcase
    end

    assign trial_nxt = trial_cnt + 1'b1;

    always_comb begin
        state_d    = state_q;
        tmr_d      = '0;
        old_d      = old_q;
        launch_d   = launch_q;
        cap_d      = cap_q;
        trials_d   = trials_q;
        mode_d     = mode_q;
        trial_d    = trial_cnt;
        err_d      = err_cnt;
        tmo_d      = tmo_cnt;
        last_bad_d = last_bad;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        trials_d   = cfg_trials;
                        mode_d     = cfg_mode;
                        trial_d    = '0;
                        err_d      = '0;
                        tmo_d      = '0;
                        last_bad_d = '0;
                        old_d      = '0;
                        if (cfg_trials == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d  = ST_SETUP;
                            launch_d = '0;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_q == TIMER_W'(HOLD_CYC - 1)) begin
                        state_d  = ST_LAUNCH;
                        launch_d = new_val;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_LAUNCH: begin
                    // A capture arriving on the final timeout cycle still counts as a capture.
                    if (ev) begin
                        cap_d   = cap_data;
                        state_d = ST_CHECK;
                    end else if (tmr_q == TIMER_W'(TMO_CYC - 1)) begin
                        if (tmo_cnt != '1) tmo_d = tmo_cnt + 1'b1;
                        trial_d  = trial_nxt;
                        launch_d = old_q;
                        state_d  = (trial_nxt == trials_q) ? ST_DONE : ST_SETUP;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (cap_q != old_q && cap_q != new_val) begin
                        if (err_cnt != '1) err_d = err_cnt + 1'b1;
                        last_bad_d = cap_q;
                    end
                    trial_d  = trial_nxt;
                    old_d    = new_val;
                    launch_d = new_val;
                    state_d  = (trial_nxt == trials_q) ? ST_DONE : ST_SETUP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            old_q       <= '0;
            launch_q    <= '0;
            cap_q       <= '0;
            trials_q    <= '0;
            mode_q      <= MODE_BIN;
            trial_cnt   <= '0;
            err_cnt     <= '0;
            tmo_cnt     <= '0;
            last_bad    <= '0;
            cap_ack_tog <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            old_q       <= old_d;
            launch_q    <= launch_d;
            cap_q       <= cap_d;
            trials_q    <= trials_d;
            mode_q      <= mode_d;
            trial_cnt   <= trial_d;
            err_cnt     <= err_d;
            tmo_cnt     <= tmo_d;
            last_bad    <= last_bad_d;
            // Every request event is acknowledged regardless of state.
            cap_ack_tog <= cap_ack_tog ^ ev;
        end
    end

    assign busy = (state_q == ST_SETUP) || (state_q == ST_LAUNCH) || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_sync_trial_sequencer.sv
// tb/tb_sync_trial_sequencer.sv - self-checking bench for sync_trial_sequencer
module tb_sync_trial_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] cfg_trials = '0;
    logic [1:0]  cfg_mode = '0;
    logic [3:0]  launch_q;
    logic        cap_req_tog = 1'b0;
    logic [3:0]  cap_data = '0;
    logic        cap_ack_tog;
    logic        busy;
    logic        done;
    logic [15:0] trial_cnt;
    logic [15:0] err_cnt;
    logic [7:0]  tmo_cnt;
    logic [3:0]  last_bad;

    int n_chk = 0;
    int n_fail = 0;
    bit gray_watch = 1'b0;

    sync_trial_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .cfg_trials (cfg_trials),
        .cfg_mode   (cfg_mode),
        .launch_q   (launch_q),
        .cap_req_tog(cap_req_tog),
        .cap_data   (cap_data),
        .cap_ack_tog(cap_ack_tog),
        .busy       (busy),
        .done       (done),
        .trial_cnt  (trial_cnt),
        .err_cnt    (err_cnt),
        .tmo_cnt    (tmo_cnt),
        .last_bad   (last_bad)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // NEW pattern from OLD, computed from the mode definitions directly.
    function automatic logic [3:0] model_new(input int mode, input logic [3:0] old);
        int idx;
        int j;
        idx = 0;
        case (mode)
            0: return 4'((int'(old) + 1) % 16);
            1: begin
                for (int i = 0; i < 16; i++) begin
                    if (4'(i ^ (i >> 1)) == old) idx = i;
                end
                j = (idx + 1) % 16;
                return 4'(j ^ (j >> 1));
            end
            2: return 4'(15 - int'(old));
            default: return {old[3:1], ~old[0]};
        endcase
    endfunction

    // Per-cycle checks: ack must follow req after sync + detect + ack latency,
    // busy/done exclusive, and Gray-mode launch flips change exactly one bit.
    logic       hist [4];
    logic       prev_busy = 1'b0;
    logic [3:0] prev_lq = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] = 1'b0;
            prev_busy = 1'b0;
        end else begin
            chk("ack_handshake", 32'(cap_ack_tog), 32'(hist[3]));
            chk("busy_done_excl", 32'(busy & done), 32'd0);
            if (gray_watch && prev_busy && busy && launch_q != prev_lq)
                chk("gray_one_bit", 32'($countones(launch_q ^ prev_lq)), 32'd1);
            hist[3] = hist[2];
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = cap_req_tog;
            prev_busy = busy;
            prev_lq = launch_q;
        end
    end

    // stop_kind: 0 abort, 1 reset, applied right after the flip of trial stop_trial.
    task automatic run_capture(input int n, input int mode, input int old_trial,
                               input int inj_trial, input logic [3:0] inj_val,
                               input int stop_trial, input int stop_kind);
        logic [3:0] old, nw, data;
        int e_err;
        logic [3:0] e_last;
        bit seen, acked;
        cfg_trials = 16'(n);
        cfg_mode = 2'(mode);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        old = '0;
        e_err = 0;
        e_last = '0;
        for (int t = 0; t < n; t++) begin
            nw = model_new(mode, old);
            seen = 1'b0;
            for (int c = 0; c < 40 && !seen; c++) begin
                tick();
                if (busy && launch_q == nw) seen = 1'b1;
            end
            chk("launch_flip", 32'(seen), 32'd1);
            if (!seen) return;
            if (t == stop_trial) begin
                if (stop_kind == 0) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk("abort_busy", 32'(busy), 32'd0);
                    chk("abort_done", 32'(done), 32'd0);
                    chk("abort_trial_cnt", 32'(trial_cnt), 32'(t));
                    chk("abort_launch_hold", 32'(launch_q), 32'(nw));
                    chk("abort_err_hold", 32'(err_cnt), 32'(e_err));
                end else begin
                    rst_n = 1'b0;
                    cap_req_tog = 1'b0;
                    #1;
                    chk("rst_launch", 32'(launch_q), 32'd0);
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_done", 32'(done), 32'd0);
                    chk("rst_trial", 32'(trial_cnt), 32'd0);
                    chk("rst_err", 32'(err_cnt), 32'd0);
                    chk("rst_tmo", 32'(tmo_cnt), 32'd0);
                    chk("rst_last_bad", 32'(last_bad), 32'd0);
                    chk("rst_ack", 32'(cap_ack_tog), 32'd0);
                    tick();
                    tick();
                    rst_n = 1'b1;
                end
                return;
            end
            data = (t == inj_trial) ? inj_val : ((t == old_trial) ? old : nw);
            if (data != old && data != nw) begin
                e_err++;
                e_last = data;
            end
            cap_data = data;
            cap_req_tog = ~cap_req_tog;
            acked = 1'b0;
            for (int c = 0; c < 20 && !acked; c++) begin
                tick();
                if (cap_ack_tog == cap_req_tog) acked = 1'b1;
            end
            chk("ack_seen", 32'(acked), 32'd1);
            if (!acked) return;
            old = nw;
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (done) seen = 1'b1;
            else tick();
        end
        chk("run_done", 32'(done), 32'd1);
        chk("run_trial_cnt", 32'(trial_cnt), 32'(n));
        chk("run_err_cnt", 32'(err_cnt), 32'(e_err));
        chk("run_tmo_cnt", 32'(tmo_cnt), 32'd0);
        chk("run_last_bad", 32'(last_bad), 32'(e_last));
        chk("run_final_launch", 32'(launch_q), 32'(old));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit fin, acked;

        repeat (3) @(negedge clk);
        chk("reset_launch", 32'(launch_q), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ack", 32'(cap_ack_tog), 32'd0);
        chk("reset_counts", 32'(trial_cnt | err_cnt | 16'(tmo_cnt) | 16'(last_bad)), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_idle", 32'({busy, done}), 32'd0);

        // Hand-computed pattern values pin the model.
        chk("model_gray_0", 32'(model_new(1, 4'h0)), 32'h1);
        chk("model_gray_1", 32'(model_new(1, 4'h1)), 32'h3);
        chk("model_gray_2", 32'(model_new(1, 4'h2)), 32'h6);
        chk("model_gray_wrap", 32'(model_new(1, 4'h8)), 32'h0);
        chk("model_bin_wrap", 32'(model_new(0, 4'hF)), 32'h0);
        chk("model_inv", 32'(model_new(2, 4'h5)), 32'hA);
        chk("model_lsb", 32'(model_new(3, 4'h7)), 32'h6);

        run_capture(8, 0, -1, -1, 4'h0, -1, 0);
        chk("run1_launch_lit", 32'(launch_q), 32'h8);

        gray_watch = 1'b1;
        run_capture(16, 1, -1, -1, 4'h0, -1, 0);
        gray_watch = 1'b0;
        chk("gray_return_zero", 32'(launch_q), 32'h0);

        // Trial 1 echoes OLD (legal); trial 3 (OLD=3, NEW=4) gets 4'hA.
        run_capture(6, 0, 1, 3, 4'hA, -1, 0);
        chk("inject_err_lit", 32'(err_cnt), 32'd1);
        chk("inject_last_bad_lit", 32'(last_bad), 32'hA);

        run_capture(3, 2, -1, -1, 4'h0, -1, 0);
        run_capture(3, 3, -1, -1, 4'h0, -1, 0);

        // Silent capture side: 2 trials x (4 hold + 255 timeout) busy cycles.
        // A start pulse mid-run with a different trial count must be ignored.
        cfg_trials = 16'd2;
        cfg_mode = 2'd0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0;
        fin = 1'b0;
        for (int c = 0; c < 1200 && !fin; c++) begin
            @(negedge clk);
            if (busy) cnt++;
            if (c == 100) begin
                start = 1'b1;
                cfg_trials = 16'd1;
            end
            if (c == 101) begin
                start = 1'b0;
                cfg_trials = 16'd2;
            end
            if (done) fin = 1'b1;
        end
        chk("tmo_done", 32'(fin), 32'd1);
        chk("tmo_busy_cycles", 32'(cnt), 32'd518);
        chk("tmo_cnt", 32'(tmo_cnt), 32'd2);
        chk("tmo_trial_cnt", 32'(trial_cnt), 32'd2);
        chk("tmo_err_cnt", 32'(err_cnt), 32'd0);

        // Abort during the LAUNCH of trial 3, then requests in IDLE are all acked.
        run_capture(8, 0, -1, -1, 4'h0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            cap_req_tog = ~cap_req_tog;
            acked = 1'b0;
            for (int c = 0; c < 20 && !acked; c++) begin
                tick();
                if (cap_ack_tog == cap_req_tog) acked = 1'b1;
            end
            chk("idle_ack", 32'(acked), 32'd1);
        end
        chk("idle_trial_hold", 32'(trial_cnt), 32'd2);
        chk("idle_stays_idle", 32'({busy, done}), 32'd0);

        cfg_trials = 16'd4;
        tick();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_over_start", 32'({busy, done}), 32'd0);

        // Reset mid-run after a bad capture (trial 1: OLD=1, NEW=2, data 4'hC).
        run_capture(8, 0, -1, 1, 4'hC, 3, 1);
        repeat (2) tick();
        chk("after_reset_idle", 32'({busy, done}), 32'd0);

        cfg_trials = 16'd0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_trials_done", 32'(done), 32'd1);
        chk("zero_trials_busy", 32'(busy), 32'd0);
        chk("zero_trials_cnt", 32'(trial_cnt), 32'd0);
        repeat (6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
